// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the K580VT57 (i8257-compatible) DMA controller.
package k580vt57_pkg;

  localparam int unsigned NCh = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StS1,
    StS2,
    StS3,
    StS4
  } dma_state_t;

  typedef enum logic [1:0] {
    XferVerify    = 2'b00,
    XferWrite     = 2'b01,
    XferRead      = 2'b10,
    XferVerifyAlt = 2'b11
  } xfer_t;

  // Mode register bit positions (bits 3:0 are the channel enables).
  localparam int unsigned ModeRotate   = 4;
  localparam int unsigned ModeTcStop   = 6;
  localparam int unsigned ModeAutoload = 7;

  localparam logic [3:0] AddrMode = 4'd8;

  function automatic logic [1:0] onehot_idx(input logic [NCh-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NCh; i++) begin
      if (oh[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/k580vt57_prio.sv
// Request arbiter: fixed (channel 0 highest) or rotating priority, one-hot grant.
module k580vt57_prio
  import k580vt57_pkg::*;
(
  input  logic [NCh-1:0] req_i,
  input  logic           rotate_i,
  input  logic [1:0]     last_i,
  output logic [NCh-1:0] grant_o
);

  logic [1:0] start;
  logic [1:0] idx;

  always_comb begin
    grant_o = '0;
    idx     = '0;
    // Rotating mode starts the search just after the last serviced channel.
    start   = rotate_i ? last_i + 2'd1 : 2'd0;
    for (int i = 0; i < NCh; i++) begin
      idx = start + 2'(i);
      if (req_i[idx] && (grant_o == '0)) grant_o[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/k580vt57_dma.sv
// Four-channel K580VT57 DMA controller top. Optional channel-2 autoload from channel 3
// is compiled in when K580VT57_AUTOLOAD_EN is defined.
module k580vt57_dma
  import k580vt57_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ce_dma,
  input  logic [3:0]          iaddr,
  input  logic [7:0]          idata,
  output logic [7:0]          odata,
  input  logic                iwe_n,
  input  logic                ird_n,
  input  logic [CHANNELS-1:0] drq,
  output logic [CHANNELS-1:0] dack,
  output logic                hrq,
  input  logic                hlda,
  output logic [15:0]         oaddr,
  output logic                omemr_n,
  output logic                omemw_n,
  output logic                tc
);

  if (CHANNELS != NCh) begin : g_bad_channels
    $error("k580vt57_dma: CHANNELS must be 4");
  end

  dma_state_t          state_q, state_d;
  logic [15:0]         addr_q [NCh];
  logic [15:0]         addr_d [NCh];
  logic [15:0]         cnt_q  [NCh];
  logic [15:0]         cnt_d  [NCh];
  logic [7:0]          mode_q, mode_d;
  logic                ff_q, ff_d;
  logic [NCh-1:0]      tcf_q, tcf_d;
  logic                upd_q, upd_d;
  logic                stat_rd_q, stat_rd_d;
  logic [7:0]          odata_q, odata_d;
  logic                iwe_q, ird_q;
  logic [1:0]          ch_q, ch_d, last_q, last_d;
  logic                hrq_q, hrq_d, memr_q, memr_d, memw_q, memw_d, tc_q, tc_d;
  logic [CHANNELS-1:0] dack_q, dack_d;
  logic [15:0]         oaddr_q, oaddr_d;

  logic [NCh-1:0] grant;
  logic [1:0]     gidx;
  logic           any_req;
  logic           do_upd, leave_s4;
  logic           wr_fall, rd_fall, rd_rise;
  logic [15:0]    sel16;
  logic [7:0]     rd_byte;
  xfer_t          xfer;

  k580vt57_prio u_prio (
    .req_i   (drq & mode_q[NCh-1:0]),
    .rotate_i(mode_q[ModeRotate]),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign gidx    = onehot_idx(grant);
  assign any_req = |grant;
  assign xfer    = xfer_t'(cnt_q[ch_q][15:14]);

  assign wr_fall = iwe_q & ~iwe_n;
  assign rd_fall = ird_q & ~ird_n;
  assign rd_rise = ~ird_q & ird_n;

  assign sel16   = iaddr[0] ? cnt_q[iaddr[2:1]] : addr_q[iaddr[2:1]];
  assign rd_byte = !iaddr[3]           ? (ff_q ? sel16[15:8] : sel16[7:0]) :
                   (iaddr == AddrMode) ? {3'b000, upd_q, tcf_q} : 8'h00;

  // Transfer state machine and registered bus outputs.
  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    dack_d   = dack_q;
    oaddr_d  = oaddr_q;
    memr_d   = memr_q;
    memw_d   = memw_q;
    tc_d     = tc_q;
    ch_d     = ch_q;
    last_d   = last_q;
    do_upd   = 1'b0;
    leave_s4 = 1'b0;
    if (ce_dma) begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_d = StHold;
            hrq_d   = 1'b1;
          end
        end
        StHold: begin
          if (!any_req) begin
            state_d = StIdle;
            hrq_d   = 1'b0;
          end else if (hlda) begin
            state_d = StS1;
            ch_d    = gidx;
            oaddr_d = addr_q[gidx];
            tc_d    = (cnt_q[gidx][13:0] == 14'd0);
          end
        end
        StS1: begin
          state_d = StS2;
          memr_d  = (xfer != XferRead);
        end
        StS2: begin
          state_d      = StS3;
          dack_d       = '0;
          dack_d[ch_q] = 1'b1;
          memw_d       = (xfer != XferWrite);
        end
        StS3: begin
          state_d = StS4;
          dack_d  = '0;
          memr_d  = 1'b1;
          memw_d  = 1'b1;
          tc_d    = 1'b0;
          do_upd  = 1'b1;
          last_d  = ch_q;
        end
        StS4: begin
          leave_s4 = 1'b1;
          // A dropped hlda lets the cycle finish here, then the bus is released.
          if (any_req && hlda) begin
            state_d = StS1;
            ch_d    = gidx;
            oaddr_d = addr_q[gidx];
            tc_d    = (cnt_q[gidx][13:0] == 14'd0);
          end else begin
            state_d = StIdle;
            hrq_d   = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
          hrq_d   = 1'b0;
        end
      endcase
    end
  end

  // Register file: DMA updates first, so a same-cycle CPU write overrides them.
  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    ff_d      = ff_q;
    tcf_d     = tcf_q;
    upd_d     = upd_q;
    stat_rd_d = stat_rd_q;
    odata_d   = odata_q;
    if (leave_s4) upd_d = 1'b0;
    if (rd_rise && stat_rd_q) begin
      tcf_d     = '0;
      stat_rd_d = 1'b0;
    end
    if (do_upd) begin
      addr_d[ch_q]       = addr_q[ch_q] + 16'd1;
      cnt_d[ch_q][13:0]  = cnt_q[ch_q][13:0] - 14'd1;
      if (cnt_q[ch_q][13:0] == 14'd0) begin
        tcf_d[ch_q] = 1'b1;
`ifdef K580VT57_AUTOLOAD_EN
        if (mode_q[ModeAutoload] && (ch_q == 2'd2)) begin
          addr_d[2] = addr_q[3];
          cnt_d[2]  = cnt_q[3];
          upd_d     = 1'b1;
        end else if (mode_q[ModeTcStop]) begin
          mode_d[ch_q] = 1'b0;
        end
`else
        if (mode_q[ModeTcStop]) mode_d[ch_q] = 1'b0;
`endif
      end
    end
    if (rd_fall) begin
      odata_d = rd_byte;
      if (!iaddr[3]) ff_d = ~ff_q;
      if (iaddr == AddrMode) stat_rd_d = 1'b1;
    end
    if (wr_fall) begin
      if (!iaddr[3]) begin
        if (iaddr[0]) begin
          cnt_d[iaddr[2:1]] = ff_q ? {idata, cnt_q[iaddr[2:1]][7:0]}
                                   : {cnt_q[iaddr[2:1]][15:8], idata};
        end else begin
          addr_d[iaddr[2:1]] = ff_q ? {idata, addr_q[iaddr[2:1]][7:0]}
                                    : {addr_q[iaddr[2:1]][15:8], idata};
        end
        ff_d = ~ff_q;
      end else if (iaddr == AddrMode) begin
        mode_d = idata;
        ff_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      hrq_q     <= 1'b0;
      dack_q    <= '0;
      oaddr_q   <= '0;
      memr_q    <= 1'b1;
      memw_q    <= 1'b1;
      tc_q      <= 1'b0;
      ch_q      <= '0;
      last_q    <= 2'd3;
      for (int i = 0; i < NCh; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      mode_q    <= '0;
      ff_q      <= 1'b0;
      tcf_q     <= '0;
      upd_q     <= 1'b0;
      stat_rd_q <= 1'b0;
      odata_q   <= '0;
      iwe_q     <= 1'b1;
      ird_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      hrq_q     <= hrq_d;
      dack_q    <= dack_d;
      oaddr_q   <= oaddr_d;
      memr_q    <= memr_d;
      memw_q    <= memw_d;
      tc_q      <= tc_d;
      ch_q      <= ch_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      ff_q      <= ff_d;
      tcf_q     <= tcf_d;
      upd_q     <= upd_d;
      stat_rd_q <= stat_rd_d;
      odata_q   <= odata_d;
      iwe_q     <= iwe_n;
      ird_q     <= ird_n;
    end
  end

  assign hrq     = hrq_q;
  assign dack    = dack_q;
  assign oaddr   = oaddr_q;
  assign omemr_n = memr_q;
  assign omemw_n = memw_q;
  assign tc      = tc_q;
  assign odata   = odata_q;

endmodule

// File: tb/tb_k580vt57_dma.sv
// Directed + randomized bench for k580vt57_dma against a register-level reference model.
module tb_k580vt57_dma;

`ifdef K580VT57_AUTOLOAD_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif

  logic        clk_sys = 1'b0, reset_n = 1'b0, ce_dma = 1'b0;
  logic [3:0]  iaddr = '0;
  logic [7:0]  idata = '0;
  logic [7:0]  odata;
  logic        iwe_n = 1'b1, ird_n = 1'b1;
  logic [3:0]  drq = '0;
  logic [3:0]  dack;
  logic        hrq, hlda = 1'b0;
  logic [15:0] oaddr;
  logic        omemr_n, omemw_n, tc;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [15:0] m_addr [4];
  logic [15:0] m_cnt  [4];
  logic [7:0]  m_mode;
  logic [3:0]  m_flags;
  int          m_last;
  bit          busy;

  always #5 clk_sys = ~clk_sys;

  k580vt57_dma #(.CHANNELS(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_dma(ce_dma),
    .iaddr(iaddr), .idata(idata), .odata(odata), .iwe_n(iwe_n), .ird_n(ird_n),
    .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda), .oaddr(oaddr),
    .omemr_n(omemr_n), .omemw_n(omemw_n), .tc(tc)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ce();
    ce_dma = 1'b1;
    tick();
    ce_dma = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    iaddr = a; idata = d; iwe_n = 1'b0;
    tick(); tick();
    iwe_n = 1'b1;
    tick();
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    iaddr = a; ird_n = 1'b0;
    tick(); tick();
    d = odata;
    ird_n = 1'b1;
    tick();
    if (a == 4'd8) m_flags = '0;
  endtask

  task automatic wr_mode(input logic [7:0] m);
    cpu_wr(4'd8, m);
    m_mode = m;
  endtask

  task automatic wr16(input int r, input logic [15:0] v);
    cpu_wr(4'(r), v[7:0]);
    cpu_wr(4'(r), v[15:8]);
    if (r % 2 == 1) m_cnt[r / 2] = v;
    else m_addr[r / 2] = v;
  endtask

  task automatic rd16(input int r, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_rd(4'(r), lo);
    cpu_rd(4'(r), hi);
    v = {hi, lo};
  endtask

  task automatic do_reset();
    reset_n = 1'b0; drq = '0; hlda = 1'b0; ce_dma = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = '0;
      m_cnt[i]  = '0;
    end
    m_mode = '0; m_flags = '0; m_last = 3; busy = 1'b0;
  endtask

  // Highest-priority enabled requester, or -1.
  function automatic int pick();
    logic [3:0] r;
    int start;
    r = drq & m_mode[3:0];
    start = m_mode[4] ? (m_last + 1) % 4 : 0;
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return -1;
  endfunction

  // Called just after entering S1; leaves the DUT sitting in S4.
  task automatic xfer(input int ch);
    logic [1:0] ty;
    bit         last;
    ty   = m_cnt[ch][15:14];
    last = (m_cnt[ch][13:0] == 14'd0);
    chk("s1_oaddr", oaddr, m_addr[ch]);
    chk("s1_tc", tc, last);
    chk("s1_dack", dack, 0);
    chk("s1_hrq", hrq, 1);
    chk("s1_memr", omemr_n, 1);
    ce();
    chk("s2_memr", omemr_n, ty != 2'b10);
    chk("s2_memw", omemw_n, 1);
    chk("s2_dack", dack, 0);
    ce();
    chk("s3_dack", dack, 32'd1 << ch);
    chk("s3_memr", omemr_n, ty != 2'b10);
    chk("s3_memw", omemw_n, ty != 2'b01);
    ce();
    chk("s4_dack", dack, 0);
    chk("s4_strobes", {omemr_n, omemw_n, tc}, 3'b110);
    m_addr[ch] = m_addr[ch] + 16'd1;
    m_cnt[ch][13:0] = m_cnt[ch][13:0] - 14'd1;
    m_last = ch;
    if (last) begin
      m_flags[ch] = 1'b1;
      if (AL && m_mode[7] && ch == 2) begin
        m_addr[2] = m_addr[3];
        m_cnt[2]  = m_cnt[3];
      end else if (m_mode[6]) begin
        m_mode[ch] = 1'b0;
      end
    end
  endtask

  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      int ch;
      ch = pick();
      if (ch < 0) break;
      if (!busy) begin
        ce();
        chk("hold_hrq", hrq, 1);
      end
      ce();
      xfer(ch);
      busy = 1'b1;
    end
  endtask

  task automatic go_idle();
    ce();
    chk("idle_hrq", hrq, 0);
    chk("idle_dack", dack, 0);
    busy = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    logic [7:0] b, e;
    e = {4'b0, m_flags};
    cpu_rd(4'd8, b);
    chk(tag, b, e);
  endtask

  task automatic chk_regs();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      rd16(2 * i, w);
      chk("rd_addr", w, m_addr[i]);
      rd16(2 * i + 1, w);
      chk("rd_cnt", w, m_cnt[i]);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [15:0] w;
    int ch;

    do_reset();
    chk("rst_hrq", hrq, 0);
    chk("rst_dack", dack, 0);
    chk("rst_oaddr", oaddr, 0);
    chk("rst_strobes", {omemr_n, omemw_n}, 2'b11);
    chk("rst_tc", tc, 0);
    chk("rst_odata", odata, 0);

    // Channel 2 memory read of 4 bytes.
    wr_mode(8'h04);
    wr16(4, 16'h76D0);
    wr16(5, 16'h8003);
    hlda = 1'b1; drq = 4'b0100;
    serve(4);
    drq = '0;
    go_idle();
    chk_status("t1_status");
    chk_status("t1_status_cleared");
    rd16(4, w);
    chk("t1_addr", w, 16'h76D4);
    rd16(5, w);
    chk("t1_cnt", w, 16'hBFFF);

    // Fixed priority: ch0 until its request drops.
    do_reset();
    wr_mode(8'h03);
    wr16(0, 16'h1000); wr16(1, 16'h40FF);
    wr16(2, 16'h2000); wr16(3, 16'h80FF);
    hlda = 1'b1; drq = 4'b0011;
    serve(3);
    drq = 4'b0010;
    serve(1);
    drq = '0;
    go_idle();

    // Rotating priority: 0,1,0,1.
    do_reset();
    wr_mode(8'h13);
    wr16(0, 16'h1000); wr16(1, 16'h40FF);
    wr16(2, 16'h2000); wr16(3, 16'h80FF);
    hlda = 1'b1; drq = 4'b0011;
    serve(4);
    chk("rot_last", m_last, 1);
    drq = '0;
    go_idle();

    // hlda withheld: hrq held, no dack; dropping drq returns to IDLE.
    do_reset();
    wr_mode(8'h01);
    wr16(0, 16'h3000); wr16(1, 16'h8005);
    drq = 4'b0001;
    ce();
    chk("hold_hrq_up", hrq, 1);
    for (int i = 0; i < 20; i++) begin
      ce();
      chk("hold_wait_hrq", hrq, 1);
      chk("hold_wait_dack", dack, 0);
    end
    drq = '0;
    ce();
    chk("hold_drop_hrq", hrq, 0);
    hlda = 1'b1; drq = 4'b0001;
    serve(1);
    drq = '0;
    go_idle();

    // TC-stop with a single write transfer.
    do_reset();
    wr_mode(8'h42);
    wr16(2, 16'hABCD); wr16(3, 16'h4000);
    hlda = 1'b1; drq = 4'b0010;
    serve(1);
    go_idle();
    for (int i = 0; i < 3; i++) begin
      ce();
      chk("tcstop_hrq", hrq, 0);
    end
    chk_status("tcstop_status");
    drq = '0;

    // Autoload of channel 2 from channel 3 (plain TC when the option is absent).
    do_reset();
    wr_mode(8'h84);
    wr16(4, 16'h2000); wr16(5, 16'h8000);
    wr16(6, 16'h1000); wr16(7, 16'h8001);
    hlda = 1'b1; drq = 4'b0100;
    serve(1);
    cpu_rd(4'd8, b);
    chk("al_status", b, {3'b0, AL, 4'b0100});
    m_flags = '0;
    serve(3);
    drq = '0;
    go_idle();
    chk_status("al_status_after");
    chk_regs();

    // Reset in S3.
    do_reset();
    wr_mode(8'h01);
    wr16(0, 16'h5555); wr16(1, 16'h8000);
    hlda = 1'b1; drq = 4'b0001;
    serve(1);
    ce(); ce(); ce();
    chk("s3_reached", dack, 4'b0001);
    reset_n = 1'b0;
    tick();
    chk("rst_s3_dack", dack, 0);
    chk("rst_s3_hrq", hrq, 0);
    chk("rst_s3_strobes", {omemr_n, omemw_n, tc}, 3'b110);
    chk("rst_s3_oaddr", oaddr, 0);
    reset_n = 1'b1; drq = '0;
    tick();
    cpu_rd(4'd8, b);
    chk("rst_s3_status", b, 0);
    rd16(0, w);
    chk("rst_s3_addr", w, 0);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] m;
      do_reset();
      m = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0,
           $urandom_range(0, 1) == 1, 4'($urandom_range(1, 15))};
      wr_mode(m);
      for (int c = 0; c < 4; c++) begin
        wr16(2 * c, 16'($urandom));
        wr16(2 * c + 1, {2'($urandom), 12'h000, 2'($urandom)});
      end
      hlda = 1'b1;
      for (int i = 0; i < 30; i++) begin
        drq = 4'($urandom);
        ch = pick();
        if (ch >= 0) serve(1);
        else if (busy) go_idle();
        else begin
          ce();
          chk("rand_idle_hrq", hrq, 0);
        end
      end
      drq = '0;
      if (busy) go_idle();
      chk_status("rand_status");
      chk_regs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
